dsram_resp: RTL and testbench

Data-SRAM responder: the memory-side end of the data_sram request interface driven by the EX stage. It owns a word-organised on-chip data array with byte write enables and services one load or store per request. It inserts a configurable number of wait states by raising a stall request toward the pipeline controller. Read data is registered at commit, so it is valid in MEM1 on the cycle the requesting instruction arrives there.

---
 rtl/dsram_resp_pkg.sv | 9 +
 rtl/dsram_resp_if.sv | 11 +
 rtl/dsram_array.sv | 24 ++
 rtl/dsram_resp.sv | 55 +++++
 tb/tb_dsram_resp.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dsram_resp_pkg.sv
// dsram_resp_pkg: shared FSM encodings, wait-state limit and byte-lane merge helper
package dsram_resp_pkg;
  localparam logic [0:0] DSRAM_ST_IDLE = 1'b0;
  localparam logic [0:0] DSRAM_ST_BUSY = 1'b1;
  localparam int DSRAM_WAIT_MAX = 15;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] we);
    for (int i = 0; i < 4; i++) byte_merge[8*i+:8] = we[i] ? new_w[8*i+:8] : old_w[8*i+:8];
  endfunction
endpackage

// File: rtl/dsram_resp_if.sv
// dsram_resp_if: data_sram request bus between the EX-stage requester and the responder
interface dsram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_dsram;
  modport master (output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, input data_sram_rdata, stallreq_dsram);
  modport slave (input data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, output data_sram_rdata, stallreq_dsram);
endinterface

// File: rtl/dsram_array.sv
// dsram_array: word array with byte-enable write and a registered read port
module dsram_array
  import dsram_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              re,
  input  logic              rz,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (wr) mem[idx] <= byte_merge(mem[idx], wdata, we);
  // rz forces a zero read for out-of-range loads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (re) q <= rz ? '0 : mem[idx];
endmodule

// File: rtl/dsram_resp.sv
// dsram_resp: data-SRAM responder with programmable wait states, range check and sticky error
module dsram_resp
  import dsram_resp_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   stall,
  dsram_resp_if.slave  bus,
  output logic         oor_err
);
  localparam int WAIT_C = WAIT > DSRAM_WAIT_MAX ? DSRAM_WAIT_MAX : WAIT;
  localparam logic HAS_WAIT = WAIT_C != 0;
  localparam logic [3:0] WAIT_M1 = 4'(HAS_WAIT ? WAIT_C - 1 : 0);
  logic [0:0] state;
  logic [3:0] cnt;
  logic       en, oor, commit;
  logic       unused;
  assign unused = ^{stall[5:4], stall[2:0], bus.data_sram_addr[1:0]};
  assign en  = bus.data_sram_en;
  assign oor = |bus.data_sram_addr[31:ADDR_W+2];
  // commit only when EX really advances so a held request lands once
  always_comb begin
    bus.stallreq_dsram = en & (state == DSRAM_ST_IDLE ? HAS_WAIT : cnt != 4'd0);
    commit = en & ~stall[3] & (state == DSRAM_ST_IDLE ? !HAS_WAIT : cnt == 4'd0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= DSRAM_ST_IDLE;
      cnt     <= '0;
      oor_err <= 1'b0;
    end else begin
      if (commit && oor) oor_err <= 1'b1;
      if (state == DSRAM_ST_IDLE) begin
        if (en && HAS_WAIT) begin
          state <= DSRAM_ST_BUSY;
          cnt   <= WAIT_M1;
        end
      end else if (!en || commit) state <= DSRAM_ST_IDLE;
      else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  dsram_array #(.ADDR_W(ADDR_W)) u_arr (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (commit & ~oor & |bus.data_sram_we),
    .re    (commit & ~|bus.data_sram_we),
    .rz    (oor),
    .we    (bus.data_sram_we),
    .idx   (bus.data_sram_addr[ADDR_W+1:2]),
    .wdata (bus.data_sram_wdata),
    .q     (bus.data_sram_rdata)
  );
endmodule

// File: tb/tb_dsram_resp.sv
// tb_dsram_resp: directed checks of three responders built with WAIT=0, 2 and 3
module tb_dsram_resp;
  import dsram_resp_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] st0 = '0, st2 = '0, st3 = '0;
  logic oor0, oor2, oor3;
  int nvec = 0, nerr = 0;
  dsram_resp_if b0 ();
  dsram_resp_if b2 ();
  dsram_resp_if b3 ();
  dsram_resp #(.ADDR_W(12), .WAIT(0)) u0 (.clk(clk), .rst_n(rst_n), .stall(st0), .bus(b0.slave), .oor_err(oor0));
  dsram_resp #(.ADDR_W(12), .WAIT(2)) u2 (.clk(clk), .rst_n(rst_n), .stall(st2), .bus(b2.slave), .oor_err(oor2));
  dsram_resp #(.ADDR_W(12), .WAIT(3)) u3 (.clk(clk), .rst_n(rst_n), .stall(st3), .bus(b3.slave), .oor_err(oor3));
  always #5 clk = ~clk;

  task automatic drive(input int d, input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    case (d)
      0: begin b0.data_sram_en = en; b0.data_sram_we = we; b0.data_sram_addr = a; b0.data_sram_wdata = wd; end
      2: begin b2.data_sram_en = en; b2.data_sram_we = we; b2.data_sram_addr = a; b2.data_sram_wdata = wd; end
      default: begin b3.data_sram_en = en; b3.data_sram_we = we; b3.data_sram_addr = a; b3.data_sram_wdata = wd; end
    endcase
  endtask

  function automatic logic sreq(input int d);
    return d == 0 ? b0.stallreq_dsram : d == 2 ? b2.stallreq_dsram : b3.stallreq_dsram;
  endfunction

  function automatic logic [31:0] rd(input int d);
    return d == 0 ? b0.data_sram_rdata : d == 2 ? b2.data_sram_rdata : b3.data_sram_rdata;
  endfunction

  // issue at a falling edge, count stalled cycles, return just after the commit edge
  task automatic do_req(input int d, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
                        output int ns, output logic [31:0] pre);
    drive(d, 1'b1, we, a, wd);
    ns = 0;
    #1;
    while (sreq(d) && ns < 20) begin
      ns++;
      @(negedge clk);
      #1;
    end
    pre = rd(d);
    @(negedge clk);
  endtask

  task automatic test_reset;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    #12;
    nvec++; if (rd(0) !== 32'h0) begin nerr++; $display("FAIL reset_rdata0 got %h want 0", rd(0)); end
    nvec++; if (rd(3) !== 32'h0) begin nerr++; $display("FAIL reset_rdata3 got %h want 0", rd(3)); end
    nvec++; if (sreq(3) !== 1'b0) begin nerr++; $display("FAIL reset_stallreq got %b want 0", sreq(3)); end
    nvec++; if (oor3 !== 1'b0) begin nerr++; $display("FAIL reset_oor got %b want 0", oor3); end
    nvec++; if (u3.state !== DSRAM_ST_IDLE) begin nerr++; $display("FAIL reset_state got %b want IDLE", u3.state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wait0_rw;
    drive(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    #1;
    nvec++; if (sreq(0) !== 1'b0) begin nerr++; $display("FAIL w0_store_stallreq got %b want 0", sreq(0)); end
    @(negedge clk);
    nvec++; if (rd(0) !== 32'h0) begin nerr++; $display("FAIL w0_store_rdata got %h want 0", rd(0)); end
    drive(0, 1'b1, 4'h0, 32'h100, 32'h0);
    #1;
    nvec++; if (sreq(0) !== 1'b0) begin nerr++; $display("FAIL w0_read_stallreq got %b want 0", sreq(0)); end
    @(negedge clk);
    nvec++; if (rd(0) !== 32'hDEADBEEF) begin nerr++; $display("FAIL w0_read got %h want deadbeef", rd(0)); end
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_byte_write;
    drive(0, 1'b1, 4'b0010, 32'h100, 32'h0000AB00);
    @(negedge clk);
    drive(0, 1'b1, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    nvec++; if (rd(0) !== 32'hDEADABEF) begin nerr++; $display("FAIL byte_write got %h want deadabef", rd(0)); end
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back;
    int ns;
    logic [31:0] pre;
    do_req(3, 4'hF, 32'h200, 32'h12345678, ns, pre);
    nvec++; if (ns !== 3) begin nerr++; $display("FAIL w3_store1_stalls got %0d want 3", ns); end
    do_req(3, 4'hF, 32'h204, 32'hCAFEF00D, ns, pre);
    nvec++; if (ns !== 3) begin nerr++; $display("FAIL w3_store2_stalls got %0d want 3", ns); end
    nvec++; if (rd(3) !== 32'h0) begin nerr++; $display("FAIL w3_store_rdata got %h want 0", rd(3)); end
    do_req(3, 4'h0, 32'h200, 32'h0, ns, pre);
    nvec++; if (ns !== 3) begin nerr++; $display("FAIL w3_read1_stalls got %0d want 3", ns); end
    nvec++; if (pre !== 32'h0) begin nerr++; $display("FAIL w3_read1_early got %h want 0", pre); end
    nvec++; if (rd(3) !== 32'h12345678) begin nerr++; $display("FAIL w3_read1 got %h want 12345678", rd(3)); end
    do_req(3, 4'h0, 32'h204, 32'h0, ns, pre);
    nvec++; if (ns !== 3) begin nerr++; $display("FAIL w3_read2_stalls got %0d want 3", ns); end
    nvec++; if (pre !== 32'h12345678) begin nerr++; $display("FAIL w3_read2_early got %h want 12345678", pre); end
    nvec++; if (rd(3) !== 32'hCAFEF00D) begin nerr++; $display("FAIL w3_read2 got %h want cafef00d", rd(3)); end
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_abort;
    int ns;
    logic [31:0] pre;
    do_req(2, 4'hF, 32'h300, 32'h11112222, ns, pre);
    nvec++; if (ns !== 2) begin nerr++; $display("FAIL w2_store_stalls got %0d want 2", ns); end
    drive(2, 1'b1, 4'hF, 32'h300, 32'h99999999);
    #1;
    nvec++; if (sreq(2) !== 1'b1) begin nerr++; $display("FAIL abort_stall1 got %b want 1", sreq(2)); end
    @(negedge clk);
    drive(2, 1'b0, 4'hF, 32'h300, 32'h99999999);
    #1;
    nvec++; if (sreq(2) !== 1'b0) begin nerr++; $display("FAIL abort_stallreq got %b want 0", sreq(2)); end
    @(negedge clk);
    nvec++; if (u2.state !== DSRAM_ST_IDLE) begin nerr++; $display("FAIL abort_state got %b want IDLE", u2.state); end
    do_req(2, 4'h0, 32'h300, 32'h0, ns, pre);
    nvec++; if (ns !== 2) begin nerr++; $display("FAIL abort_read_stalls got %0d want 2", ns); end
    nvec++; if (rd(2) !== 32'h11112222) begin nerr++; $display("FAIL abort_read got %h want 11112222", rd(2)); end
    drive(2, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_stall_hold;
    drive(0, 1'b1, 4'hF, 32'h104, 32'h55AA55AA);
    @(negedge clk);
    drive(0, 1'b1, 4'hF, 32'h108, 32'h0);
    @(negedge clk);
    st0 = 6'b001000;
    drive(0, 1'b1, 4'h0, 32'h104, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nvec++; if (rd(0) !== 32'hDEADABEF) begin nerr++; $display("FAIL hold_read_early cyc %0d got %h want deadabef", i, rd(0)); end
    end
    st0 = 6'b0;
    @(negedge clk);
    nvec++; if (rd(0) !== 32'h55AA55AA) begin nerr++; $display("FAIL hold_read got %h want 55aa55aa", rd(0)); end
    st0 = 6'b001000;
    drive(0, 1'b1, 4'hF, 32'h108, 32'h0F0F0F0F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nvec++; if (u0.u_arr.mem[66] !== 32'h0) begin nerr++; $display("FAIL hold_store_early cyc %0d got %h want 0", i, u0.u_arr.mem[66]); end
    end
    st0 = 6'b0;
    @(negedge clk);
    nvec++; if (rd(0) !== 32'h55AA55AA) begin nerr++; $display("FAIL hold_store_rdata got %h want 55aa55aa", rd(0)); end
    drive(0, 1'b1, 4'h0, 32'h108, 32'h0);
    @(negedge clk);
    nvec++; if (rd(0) !== 32'h0F0F0F0F) begin nerr++; $display("FAIL hold_store got %h want 0f0f0f0f", rd(0)); end
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_oor_and_reset;
    int ns;
    logic [31:0] pre;
    do_req(3, 4'h0, 32'h0001_0000, 32'h0, ns, pre);
    nvec++; if (ns !== 3) begin nerr++; $display("FAIL oor_stalls got %0d want 3", ns); end
    nvec++; if (rd(3) !== 32'h0) begin nerr++; $display("FAIL oor_rdata got %h want 0", rd(3)); end
    nvec++; if (oor3 !== 1'b1) begin nerr++; $display("FAIL oor_flag got %b want 1", oor3); end
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    nvec++; if (oor3 !== 1'b1) begin nerr++; $display("FAIL oor_sticky got %b want 1", oor3); end
    drive(3, 1'b1, 4'hF, 32'h200, 32'hDEAD0000);
    @(negedge clk);
    nvec++; if (u3.state !== DSRAM_ST_BUSY) begin nerr++; $display("FAIL rst_pre_state got %b want BUSY", u3.state); end
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    nvec++; if (u3.state !== DSRAM_ST_IDLE) begin nerr++; $display("FAIL rst_state got %b want IDLE", u3.state); end
    nvec++; if (sreq(3) !== 1'b0) begin nerr++; $display("FAIL rst_stallreq got %b want 0", sreq(3)); end
    nvec++; if (oor3 !== 1'b0) begin nerr++; $display("FAIL rst_oor got %b want 0", oor3); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(3, 4'h0, 32'h200, 32'h0, ns, pre);
    nvec++; if (rd(3) !== 32'h12345678) begin nerr++; $display("FAIL rst_no_write got %h want 12345678", rd(3)); end
    drive(3, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_wait0_rw;
    test_byte_write;
    test_back_to_back;
    test_abort;
    test_stall_hold;
    test_oor_and_reset;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
